// File: rtl/sr_command_conditioner_pkg.sv
// Shared types for the SR latch command conditioner: arbiter state encoding.
package sr_cond_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        SET      = 2'd1,
        RESET    = 2'd2,
        CONFLICT = 2'd3
    } sr_state_e;

endpackage

// File: rtl/sr_command_conditioner_if.sv
// Switch inputs and latch command outputs of the SR command conditioner.
interface sr_command_conditioner_if;

    logic SwS;
    logic SwR;
    logic S;
    logic R;
    logic Gate;
    logic Conflict;

    // Switch side: drives raw requests, observes latch commands.
    modport master (
        output SwS,
        output SwR,
        input  S,
        input  R,
        input  Gate,
        input  Conflict
    );

    // Conditioner side.
    modport slave (
        input  SwS,
        input  SwR,
        output S,
        output R,
        output Gate,
        output Conflict
    );

endinterface

// File: rtl/sr_command_conditioner_debounce.sv
// One input channel: multi-flop synchroniser followed by a counting debouncer.
module sr_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_s;
    logic                   stable_q;
    logic                   stable_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    // Synchroniser shift and debounce counter next-state.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
        sync_s   = sync_q[SYNC_STAGES-1];
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync_s;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/sr_command_conditioner.sv
// Debounces set/reset switches and arbitrates them into exclusive latch commands.
// Define SR_COND_PULSE_EN for single-cycle S/R pulses on state entry (default: level).
module sr_command_conditioner
    import sr_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    sr_command_conditioner_if.slave  bus
);

    logic      stable_s;
    logic      stable_r;
    logic [1:0] req_s;
    sr_state_e state_q;
    sr_state_e state_d;
    logic      s_q;
    logic      s_d;
    logic      r_q;
    logic      r_d;
    logic      gate_q;
    logic      gate_d;
    logic      conflict_q;
    logic      conflict_d;

    sr_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan_s (
        .clk    (Clk),
        .rst    (Reset),
        .raw    (bus.SwS),
        .stable (stable_s)
    );

    sr_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan_r (
        .clk    (Clk),
        .rst    (Reset),
        .raw    (bus.SwR),
        .stable (stable_r)
    );

    assign req_s = {stable_s, stable_r};

    // Arbiter next state; an already-granted request keeps priority over a late one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                case (req_s)
                    2'b10:   state_d = SET;
                    2'b01:   state_d = RESET;
                    2'b11:   state_d = CONFLICT;
                    default: state_d = IDLE;
                endcase
            end
            SET: begin
                case (req_s)
                    2'b00:   state_d = IDLE;
                    2'b01:   state_d = RESET;
                    default: state_d = SET;
                endcase
            end
            RESET: begin
                case (req_s)
                    2'b00:   state_d = IDLE;
                    2'b10:   state_d = SET;
                    default: state_d = RESET;
                endcase
            end
            CONFLICT: begin
                case (req_s)
                    2'b00:   state_d = IDLE;
                    2'b10:   state_d = SET;
                    2'b01:   state_d = RESET;
                    default: state_d = CONFLICT;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so outputs change on the same edge as the state.
    always_comb begin
`ifdef SR_COND_PULSE_EN
        s_d = (state_d == SET)   && (state_q != SET);
        r_d = (state_d == RESET) && (state_q != RESET);
`else
        s_d = (state_d == SET);
        r_d = (state_d == RESET);
`endif
        gate_d     = s_d | r_d;
        conflict_d = stable_s & stable_r;
    end

    // Arbiter state and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            gate_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            r_q        <= r_d;
            gate_q     <= gate_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.Gate     = gate_q;
    assign bus.Conflict = conflict_q;

endmodule

// File: tb/tb_sr_command_conditioner.sv
// Directed bench for sr_command_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2 (latency 7).
module tb_sr_command_conditioner;

`ifdef SR_COND_PULSE_EN
    localparam logic LVL = 1'b0;
`else
    localparam logic LVL = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    sr_command_conditioner_if bus_if ();

    sr_command_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic s, input logic r,
                             input logic g, input logic c);
        check({tag, ".S"},        bus_if.S,        s);
        check({tag, ".R"},        bus_if.R,        r);
        check({tag, ".Gate"},     bus_if.Gate,     g);
        check({tag, ".Conflict"}, bus_if.Conflict, c);
    endtask

    initial begin
        logic seen;
        bus_if.SwS = 1'b0;
        bus_if.SwR = 1'b0;
        tick(3);
        check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Set request from IDLE: output at edge 7.
        bus_if.SwS = 1'b1;
        tick(6);
        check_out("set_e6", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("set_e7", 1'b1, 1'b0, 1'b1, 1'b0);
        tick(5);
        check_out("set_hold", LVL, 1'b0, LVL, 1'b0);
        bus_if.SwS = 1'b0;
        tick(6);
        check("set_rel_e6.S", bus_if.S, LVL);
        tick(1);
        check_out("set_rel_e7", 1'b0, 1'b0, 1'b0, 1'b0);

        // Short bounce of 3 edges must be filtered.
        bus_if.SwS = 1'b1;
        tick(3);
        bus_if.SwS = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen = seen | bus_if.S | bus_if.R | bus_if.Gate | bus_if.Conflict;
        end
        check("bounce_any_out", seen, 1'b0);

        // Simultaneous requests -> CONFLICT, then release R -> SET.
        bus_if.SwS = 1'b1;
        bus_if.SwR = 1'b1;
        tick(6);
        check_out("both_e6", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("both_e7", 1'b0, 1'b0, 1'b0, 1'b1);
        bus_if.SwR = 1'b0;
        tick(6);
        check_out("dropR_e6", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        check_out("dropR_e7", 1'b1, 1'b0, 1'b1, 1'b0);

        // In SET, late R request: SET holds, Conflict flags; then drop S -> RESET.
        bus_if.SwR = 1'b1;
        tick(6);
        check("lateR_e6.Conflict", bus_if.Conflict, 1'b0);
        tick(1);
        check_out("lateR_e7", LVL, 1'b0, LVL, 1'b1);
        bus_if.SwS = 1'b0;
        tick(6);
        check("dropS_e6.R", bus_if.R, 1'b0);
        tick(1);
        check_out("dropS_e7", 1'b0, 1'b1, 1'b1, 1'b0);
        bus_if.SwR = 1'b0;
        tick(7);
        check_out("idle_again", 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while in SET.
        bus_if.SwS = 1'b1;
        tick(7);
        check("pre_rst.S", bus_if.S, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        check_out("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(6);
        check("post_rst_e6.S", bus_if.S, 1'b0);
        tick(1);
        check_out("post_rst_e7", 1'b1, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_command_conditioner.md
# sr_command_conditioner

Upstream input stage for the gated SR latch on the board. It synchronises and debounces two raw slide-switch inputs (set request, reset request) and arbitrates them into clean, mutually exclusive set/reset commands plus a gate enable that drive the latch's S, R and Clk inputs directly. The latch's forbidden S=R=1 gated condition can never be produced by this block.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive clock edges a synchronised input must differ from its stable value before the stable value flips; legal range ≥2.
- SYNC_STAGES, 2: synchroniser flop depth per input; legal range ≥2.

- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- SwS  input  1  raw set request, asynchronous to Clk, may bounce.
- SwR  input  1  raw reset request, asynchronous to Clk, may bounce.
- S  output  1  set command to latch.
- R  output  1  reset command to latch.
- Gate  output  1  latch gate enable; equals S|R.
- Conflict  output  1  both debounced requests high.

## Operation
- Per channel: SYNC_STAGES-flop synchroniser -> debouncer (stable bit, counter of width $clog2(DEBOUNCE_CYCLES)).
- Debouncer: at each edge, if sync==stable, counter<=0; otherwise, if counter==DEBOUNCE_CYCLES-1, stable<=sync and counter<=0, else counter<=counter+1.
- Arbiter: Moore FSM on (stable_s, stable_r), states IDLE, SET, RESET, CONFLICT:
  - IDLE: 10->SET, 01->RESET, 11->CONFLICT, 00 stay.
  - SET: 00->IDLE, 01->RESET, 10/11 stay (first request wins).
  - RESET: 00->IDLE, 10->SET, 01/11 stay.
  - CONFLICT: 00->IDLE, 10->SET, 01->RESET, 11 stay.
- S=1 only in SET; R=1 only in RESET; CONFLICT drives S=R=Gate=0.
- Conflict: registered (stable_s & stable_r), updated on the same edge as the state.
- All outputs are registered; S and R are never high together.

## Timing
- Reset: all sync flops 0, stable bits 0, counters 0, state IDLE; S=R=Gate=Conflict=0 while Reset is high and until the first qualifying change.
- Reset mid-operation clears everything immediately (asynchronously); pending debounce counts are discarded.
- Latency: raw level first present before edge 1 and held -> output change at edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (19 with defaults).
- Any bounce shorter than DEBOUNCE_CYCLES synchronised cycles resets the counter; no output change.
- Both stable bits flipping on the same edge: arbiter evaluates the new pair once (IDLE+11 -> CONFLICT).
- Counter never wraps; it is cleared on a match or a flip.

## Configuration
- SR_COND_PULSE_EN defined: S (or R) is high for exactly one cycle, the first cycle after entering SET (or RESET); Gate=S|R follows; Conflict is unchanged.
- Undefined: S/R/Gate remain high for the entire residency in SET/RESET (level mode).

## Structure
- Package sr_cond_pkg: state enum typedef (IDLE, SET, RESET, CONFLICT) and state-encoding width constant.
- Sub-module sr_debounce_channel (synchroniser + debouncer, parameterised), instantiated twice; FSM and output registers live in the top.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2 (latency 7), level mode unless noted.
- SwS=1 from edge 1 onward -> S=1, Gate=1 at edge 7; R=0, Conflict=0 throughout.
- SwS pulses high for 3 edges then returns low -> S, R, Gate stay 0 forever.
- SwS and SwR rise together -> at edge 7: Conflict=1, S=R=Gate=0; then drop SwR -> S=1 and Conflict=0 exactly 7 edges later.
- In SET, raise SwR -> S stays 1, Conflict=1 at +7; then drop SwS -> R=1, S=0 at +7.
- In SET, assert Reset mid-cycle -> S=Gate=Conflict=0 immediately; with SwS still high, S=1 again 7 edges after Reset deasserts.
- With SR_COND_PULSE_EN: SwS held high -> S=Gate=1 for exactly one cycle at edge 7, then 0 while held.
